// File: rtl/vc_pop_arbiter_if.sv
// vc_pop_arbiter_if
// Bundles the arbiter's FIFO-side and downstream-side signals.
//   master : arbiter view (consumes FIFO status/data and pause, drives pops and output word)
//   slave  : environment view (FIFOs + downstream stage)
// Signals:
//   empty_fifo_VC0/1  FIFO empty flags (registered by the FIFO)
//   data_out_VC0/1    FIFO read data, valid the cycle after a pop
//   pause_in          downstream almost-full
//   pop_VC0/1_fifo    pop requests, combinational
//   data_out          registered arbitrated word
//   valid_out         data_out valid
//   vc_id_out         source VC of data_out
//   state_out         00 IDLE, 01 RUN, 10 HOLD
interface vc_pop_arbiter_if #(
    parameter int data_width = 6
);
    logic                  empty_fifo_VC0;
    logic                  empty_fifo_VC1;
    logic [data_width-1:0] data_out_VC0;
    logic [data_width-1:0] data_out_VC1;
    logic                  pause_in;
    logic                  pop_VC0_fifo;
    logic                  pop_VC1_fifo;
    logic [data_width-1:0] data_out;
    logic                  valid_out;
    logic                  vc_id_out;
    logic [1:0]            state_out;

    modport master (
        input  empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1, pause_in,
        output pop_VC0_fifo, pop_VC1_fifo, data_out, valid_out, vc_id_out, state_out
    );

    modport slave (
        output empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1, pause_in,
        input  pop_VC0_fifo, pop_VC1_fifo, data_out, valid_out, vc_id_out, state_out
    );
endinterface

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter
// Weighted two-VC pop arbiter. VC0 gets up to WEIGHT_VC0 consecutive grants
// while VC1 waits, then VC1 is served, so VC1 can never be starved.
// Pops are combinational; the popped word is registered two cycles later
// together with a valid flag and its VC tag.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    vc_pop_arbiter_if.master (FIFO status/data, pause, pops, output word, state)
module vc_pop_arbiter #(
    parameter int data_width = 6,
    parameter int WEIGHT_VC0 = 4
) (
    input  logic               clk,
    input  logic               reset,
    vc_pop_arbiter_if.master   bus
);
    localparam logic [2:0] WEIGHT = 3'(WEIGHT_VC0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t                state;
    logic [2:0]            credit;
    logic                  sel_v;
    logic                  sel_id;
    logic [data_width-1:0] data_q;
    logic                  valid_q;
    logic                  vc_id_q;

    logic elig0, elig1, go, pop0, pop1;

    // Credit counts VC0 grants since VC1 was last served; once it reaches
    // WEIGHT a waiting VC1 wins. Reset gates pops in the same cycle.
    always_comb begin
        elig0 = !bus.empty_fifo_VC0;
        elig1 = !bus.empty_fifo_VC1;
        go    = reset && !bus.pause_in;
        pop0  = go && elig0 && (!elig1 || (credit < WEIGHT));
        pop1  = go && elig1 && (!elig0 || (credit >= WEIGHT));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            credit  <= '0;
            sel_v   <= 1'b0;
            sel_id  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            vc_id_q <= 1'b0;
            state   <= IDLE;
        end else begin
            // Saturate rather than wrap when VC0 streams alone.
            if (pop1)
                credit <= '0;
            else if (pop0 && (credit < WEIGHT))
                credit <= credit + 3'd1;

            // Stage 1: remember which FIFO will present data next cycle.
            sel_v <= pop0 || pop1;
            if (pop0 || pop1)
                sel_id <= pop1;

            // Stage 2: capture the FIFO read data; hold the word when idle.
            valid_q <= sel_v;
            if (sel_v) begin
                data_q  <= sel_id ? bus.data_out_VC1 : bus.data_out_VC0;
                vc_id_q <= sel_id;
            end

            if (bus.pause_in)
                state <= HOLD;
            else if (elig0 || elig1)
                state <= RUN;
            else
                state <= IDLE;
        end
    end

    assign bus.pop_VC0_fifo = pop0;
    assign bus.pop_VC1_fifo = pop1;
    assign bus.data_out     = data_q;
    assign bus.valid_out    = valid_q;
    assign bus.vc_id_out    = vc_id_q;
    assign bus.state_out    = state;
endmodule
